// File: rtl/neuron_update_sequencer_pkg.sv
// Shared types and helpers for the neuron update sequencer.
package neuron_update_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_WRITE  = 3'd4,
        ST_EMIT   = 3'd5,
        ST_INIT   = 3'd6,
        ST_DONE   = 3'd7
    } seq_state_t;

    // Limit a requested neuron count to the addressable range 2^aw.
    function automatic int unsigned clamp_count(input int unsigned n, input int unsigned aw);
        int unsigned limit;
        limit = 32'd1 << aw;
        return (n > limit) ? limit : n;
    endfunction

endpackage

// File: rtl/neuron_update_sequencer_latency.sv
// Load/decrement down-counter that times the state-RAM read latency.
module seq_latency_counter #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/neuron_update_sequencer.sv
// Per-timestep controller walking a neuron layer through one shared LIF unit.
module neuron_update_sequencer
    import neuron_update_sequencer_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  initialize,
    input  logic [ADDR_WIDTH:0]   num_neurons,
    output logic                  state_rd_en,
    output logic [ADDR_WIDTH-1:0] state_rd_addr,
    output logic                  state_wr_en,
    output logic                  state_wr_init,
    output logic [ADDR_WIDTH-1:0] state_wr_addr,
    output logic                  neuron_update_en,
    input  logic                  spike_in,
    output logic                  spike_valid,
    input  logic                  spike_ready,
    output logic [ADDR_WIDTH-1:0] spike_addr,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned CW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    // WAIT lasts RD_LATENCY cycles: counter starts at RD_LATENCY-1 and exits on zero.
    localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LATENCY - 1);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [ADDR_WIDTH-1:0] index;
    logic [ADDR_WIDTH:0]   n_lat;
    logic [ADDR_WIDTH:0]   n_req;
    logic                  go;
    logic                  last;
    logic                  lat_zero;

    assign n_req = (ADDR_WIDTH+1)'(clamp_count(32'(num_neurons), ADDR_WIDTH));
    assign go    = start | initialize;
    // Terminal compare against the latched count, so index N-1 = 2^ADDR_WIDTH-1 never wraps.
    assign last  = ({1'b0, index} == (n_lat - (ADDR_WIDTH+1)'(1)));

    seq_latency_counter #(
        .WIDTH (CW)
    ) u_latency (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (state == ST_READ),
        .load_value (LAT_LOAD),
        .dec        (state == ST_WAIT),
        .zero       (lat_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Index and latched layer size; index advances only after a neuron is fully retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index <= '0;
            n_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        index <= '0;
                        n_lat <= n_req;
                    end
                end
                ST_WRITE: if (!spike_in && !last)   index <= index + ADDR_WIDTH'(1);
                ST_EMIT:  if (spike_ready && !last) index <= index + ADDR_WIDTH'(1);
                ST_INIT:  if (!last)                index <= index + ADDR_WIDTH'(1);
                default: ;
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (initialize) begin
                    state_next = (n_req == '0) ? ST_DONE : ST_INIT;
                end else if (start) begin
                    state_next = (n_req == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ:   state_next = ST_WAIT;
            ST_WAIT:   if (lat_zero) state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_WRITE;
            ST_WRITE: begin
                if (spike_in)  state_next = ST_EMIT;
                else if (last) state_next = ST_DONE;
                else           state_next = ST_READ;
            end
            ST_EMIT: begin
                if (spike_ready) state_next = last ? ST_DONE : ST_READ;
            end
            ST_INIT:   if (last) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state register and index.
    always_comb begin
        state_rd_en      = 1'b0;
        state_rd_addr    = '0;
        state_wr_en      = 1'b0;
        state_wr_init    = 1'b0;
        state_wr_addr    = '0;
        neuron_update_en = 1'b0;
        spike_valid      = 1'b0;
        spike_addr       = '0;
        busy             = (state != ST_IDLE);
        done             = 1'b0;
        case (state)
            ST_READ: begin
                state_rd_en   = 1'b1;
                state_rd_addr = index;
            end
            ST_UPDATE: neuron_update_en = 1'b1;
            ST_WRITE: begin
                state_wr_en   = 1'b1;
                state_wr_addr = index;
            end
            ST_EMIT: begin
                spike_valid = 1'b1;
                spike_addr  = index;
            end
            ST_INIT: begin
                state_wr_en   = 1'b1;
                state_wr_init = 1'b1;
                state_wr_addr = index;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_update_sequencer.sv
// Self-checking bench: observed event trace vs. a timing model built from the sweep rules.
module tb_neuron_update_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned L  = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          initialize;
    logic [AW:0]   num_neurons;
    logic          state_rd_en;
    logic [AW-1:0] state_rd_addr;
    logic          state_wr_en;
    logic          state_wr_init;
    logic [AW-1:0] state_wr_addr;
    logic          neuron_update_en;
    logic          spike_in;
    logic          spike_valid;
    logic          spike_ready;
    logic [AW-1:0] spike_addr;
    logic          busy;
    logic          done;
    logic [30:0]   outs;

    int            checks = 0;
    int            failures = 0;
    int unsigned   cyc = 0;
    bit            mon_on = 1'b0;
    int unsigned   busy_cnt;
    int unsigned   emit_cnt;
    logic [63:0]   obs_q[$];
    logic [63:0]   exp_q[$];
    bit            spike_mask[256];
    int unsigned   stall_tab[256];

    neuron_update_sequencer #(
        .ADDR_WIDTH (AW),
        .RD_LATENCY (L)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .initialize       (initialize),
        .num_neurons      (num_neurons),
        .state_rd_en      (state_rd_en),
        .state_rd_addr    (state_rd_addr),
        .state_wr_en      (state_wr_en),
        .state_wr_init    (state_wr_init),
        .state_wr_addr    (state_wr_addr),
        .neuron_update_en (neuron_update_en),
        .spike_in         (spike_in),
        .spike_valid      (spike_valid),
        .spike_ready      (spike_ready),
        .spike_addr       (spike_addr),
        .busy             (busy),
        .done             (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign outs = {state_rd_en, state_rd_addr, state_wr_en, state_wr_init, state_wr_addr,
                   neuron_update_en, spike_valid, spike_addr, busy, done};

    // Unit model: spike flag per neuron; consumer holds ready low stall_tab[addr] cycles.
    assign spike_in    = state_wr_en && spike_mask[state_wr_addr];
    assign spike_ready = spike_valid && (emit_cnt >= stall_tab[spike_addr]);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          emit_cnt <= 0;
        else if (spike_valid && !spike_ready) emit_cnt <= emit_cnt + 1;
        else                                 emit_cnt <= 0;
    end

    function automatic logic [63:0] ev(input int unsigned k, input int unsigned c, input int unsigned a);
        return {k[7:0], c, a[23:0]};
    endfunction

    // Event kinds: 1 read, 2 write, 3 init write, 4 update, 5 spike handshake, 6 done, 7 spike valid.
    always @(negedge clk) begin
        if (mon_on) begin
            if (state_rd_en)      obs_q.push_back(ev(1, cyc, state_rd_addr));
            if (neuron_update_en) obs_q.push_back(ev(4, cyc, 0));
            if (state_wr_en)      obs_q.push_back(ev(state_wr_init ? 3 : 2, cyc, state_wr_addr));
            if (spike_valid)      obs_q.push_back(ev(7, cyc, spike_addr));
            if (spike_valid && spike_ready) obs_q.push_back(ev(5, cyc, spike_addr));
            if (done)             obs_q.push_back(ev(6, cyc, 0));
            if (busy)             busy_cnt++;
        end
    end

    // Reference timing: sweep start sampled at the edge ending cycle e0.
    function automatic void build_expected(input int unsigned n_req, input bit init,
                                           input int unsigned e0, output int unsigned done_c);
        int unsigned n, t, w;
        n = (n_req > 256) ? 256 : n_req;
        exp_q.delete();
        t = e0;
        if (n != 0 && init) begin
            for (int unsigned i = 0; i < n; i++) exp_q.push_back(ev(3, t + 1 + i, i));
            t = t + n;
        end else if (n != 0) begin
            for (int unsigned i = 0; i < n; i++) begin
                exp_q.push_back(ev(1, t + 1, i));
                exp_q.push_back(ev(4, t + 2 + L, 0));
                w = t + 3 + L;
                exp_q.push_back(ev(2, w, i));
                if (spike_mask[i]) begin
                    for (int unsigned k = 0; k <= stall_tab[i]; k++) begin
                        exp_q.push_back(ev(7, w + 1 + k, i));
                        if (k == stall_tab[i]) exp_q.push_back(ev(5, w + 1 + k, i));
                    end
                    t = w + 1 + stall_tab[i];
                end else begin
                    t = w;
                end
            end
        end
        done_c = t + 1;
        exp_q.push_back(ev(6, done_c, 0));
    endfunction

    function automatic void clear_tables();
        for (int i = 0; i < 256; i++) begin
            spike_mask[i] = 1'b0;
            stall_tab[i]  = 0;
        end
    endfunction

    task automatic run_sweep(input int unsigned n, input bit s, input bit ini, input bit poke,
                             output int unsigned e0);
        bit seen;
        obs_q.delete();
        busy_cnt    = 0;
        mon_on      = 1'b1;
        num_neurons = n[AW:0];
        start       = s;
        initialize  = ini;
        e0          = cyc;
        @(negedge clk);
        start      = 1'b0;
        initialize = 1'b0;
        seen       = 1'b0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                start = poke && (k % 9 == 4);
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clk);
        mon_on = 1'b0;
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout got=no_done required=done n=%0d", n);
        end
    endtask

    task automatic test_reset();
        int unsigned e0, dc;
        bit          bad;
        bit          hit;
        rst_n = 1'b0; start = 1'b0; initialize = 1'b0; num_neurons = '0;
        clear_tables();
        #23;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outputs got=%h required=0", outs); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b required=0", busy); end
        @(negedge clk);
        num_neurons = 9'd3; start = 1'b1;
        @(negedge clk); start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            if (neuron_update_en) hit = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!hit) begin failures++; $display("FAIL reach_update got=none required=update_en"); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL async_reset_outputs got=%h required=0", outs); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy got=%b required=0", busy); end
        @(negedge clk);
        run_sweep(2, 1'b1, 1'b0, 1'b0, e0);
        build_expected(2, 1'b0, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL restart_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL restart_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
    endtask

    task automatic test_sweep_basic();
        int unsigned e0, dc, got_done;
        bit          bad;
        clear_tables();
        run_sweep(4, 1'b1, 1'b0, 1'b0, e0);
        build_expected(4, 1'b0, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL basic_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL basic_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
        got_done = 0;
        foreach (obs_q[i]) if (obs_q[i][63:56] == 8'd6) got_done = obs_q[i][55:24] - e0;
        checks++;
        if (got_done != 17) begin failures++; $display("FAIL basic_done_cycle got=%0d required=17", got_done); end
        checks++;
        if (busy_cnt != dc - e0) begin failures++; $display("FAIL basic_busy got=%0d required=%0d", busy_cnt, dc - e0); end
    endtask

    task automatic test_spike_stall();
        int unsigned e0, dc, nvalid, nhs;
        bit          bad;
        clear_tables();
        spike_mask[1] = 1'b1;
        stall_tab[1]  = 5;
        run_sweep(3, 1'b1, 1'b0, 1'b0, e0);
        build_expected(3, 1'b0, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL spike_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL spike_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
        nvalid = 0; nhs = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i][63:56] == 8'd7 && obs_q[i][23:0] == 24'd1) nvalid++;
            if (obs_q[i][63:56] == 8'd5) nhs++;
        end
        checks++;
        if (nvalid != 6) begin failures++; $display("FAIL spike_hold got=%0d required=6", nvalid); end
        checks++;
        if (nhs != 1) begin failures++; $display("FAIL spike_events got=%0d required=1", nhs); end
    endtask

    task automatic test_init_priority();
        int unsigned e0, dc;
        bit          bad;
        clear_tables();
        spike_mask[2] = 1'b1;
        run_sweep(5, 1'b1, 1'b1, 1'b0, e0);
        build_expected(5, 1'b1, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL init_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL init_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
    endtask

    task automatic test_zero();
        int unsigned e0, dc;
        bit          bad;
        clear_tables();
        run_sweep(0, 1'b1, 1'b0, 1'b0, e0);
        build_expected(0, 1'b0, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL zero_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL zero_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
        checks++;
        if (busy_cnt != 1) begin failures++; $display("FAIL zero_busy got=%0d required=1", busy_cnt); end
    endtask

    task automatic test_full_range();
        int unsigned e0, dc;
        bit          bad;
        clear_tables();
        run_sweep(256, 1'b1, 1'b0, 1'b1, e0);
        build_expected(256, 1'b0, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL full_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL full_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
        run_sweep(400, 1'b0, 1'b1, 1'b0, e0);
        build_expected(400, 1'b1, e0, dc);
        checks++;
        bad = 1'b0;
        if (obs_q.size() != exp_q.size()) begin
            bad = 1'b1;
            $display("FAIL clamp_trace_len got=%0d required=%0d", obs_q.size(), exp_q.size());
        end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
            bad = 1'b1;
            $display("FAIL clamp_trace idx=%0d got=%h required=%h", i, obs_q[i], exp_q[i]);
        end
        if (bad) failures++;
    endtask

    task automatic test_random();
        int unsigned e0, dc, n;
        bit          ini, bad;
        for (int it = 0; it < 8; it++) begin
            n   = $urandom_range(0, 20);
            ini = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 256; i++) begin
                spike_mask[i] = ($urandom_range(0, 2) == 0);
                stall_tab[i]  = $urandom_range(0, 3);
            end
            run_sweep(n, 1'b1, ini, 1'b1, e0);
            build_expected(n, ini, e0, dc);
            checks++;
            bad = 1'b0;
            if (obs_q.size() != exp_q.size()) begin
                bad = 1'b1;
                $display("FAIL rand_trace_len it=%0d got=%0d required=%0d", it, obs_q.size(), exp_q.size());
            end else foreach (exp_q[i]) if (!bad && obs_q[i] !== exp_q[i]) begin
                bad = 1'b1;
                $display("FAIL rand_trace it=%0d idx=%0d got=%h required=%h", it, i, obs_q[i], exp_q[i]);
            end
            if (bad) failures++;
            checks++;
            if (busy_cnt != dc - e0) begin
                failures++;
                $display("FAIL rand_busy it=%0d got=%0d required=%0d", it, busy_cnt, dc - e0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep_basic();
        test_spike_stall();
        test_init_priority();
        test_zero();
        test_full_range();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1);
    end

endmodule
